// File: rtl/elastic_pipe_reg.sv
// Elastic register chain: DEPTH stages with a valid/ready handshake, bubble collapsing,
// a global hold (stall) and a synchronous flush.
`timescale 1ns/1ps
module elastic_pipe_reg #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             hold,
  input  logic             flush,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] r_vld;
  logic [WIDTH-1:0] r_dat [DEPTH];
  logic [WIDTH-1:0] w_src [DEPTH];
  logic [DEPTH-1:0] w_mv;
  logic [DEPTH-1:0] w_ld;
  logic             w_act;
  logic             w_rdy0;
  logic [CNT_W-1:0] w_cnt;

  assign w_act = ~hold & ~flush;

  // Ready ripples from the output back to stage 0; a stage is ready when it is
  // empty or hands its word on, so any bubble downstream lets upstream advance.
  always_comb begin
    logic w_acc;
    w_acc = out_ready;
    w_mv  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      w_mv[i] = r_vld[i] & w_acc;
      w_acc   = ~r_vld[i] | w_acc;
    end
    w_rdy0 = w_acc;
  end

  assign in_ready = w_rdy0 & w_act;

  assign w_src[0] = in_data;
  for (genvar g = 1; g < DEPTH; g++) begin : g_src
    assign w_src[g] = r_dat[g-1];
  end

  always_comb begin
    w_ld    = '0;
    w_ld[0] = in_valid & in_ready;
    for (int i = 1; i < DEPTH; i++) begin
      w_ld[i] = w_mv[i-1] & w_act;
    end
  end

  // Flush clears occupancy only; data words are left stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_dat[i] <= '0;
      end
    end else if (flush) begin
      r_vld <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_ld[i]) begin
          r_vld[i] <= 1'b1;
          r_dat[i] <= w_src[i];
        end else if (w_mv[i] & w_act) begin
          r_vld[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_cnt = w_cnt + CNT_W'(r_vld[i]);
    end
  end

  assign count     = w_cnt;
  assign out_valid = r_vld[DEPTH-1] & w_act;
  assign out_data  = r_dat[DEPTH-1];

endmodule
